// File: rtl/parking_entry_arbiter_if.sv
// Lane sensor/keypad inputs and gate/alarm/occupancy outputs of parking_entry_arbiter.
interface parking_entry_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             req_a;
    logic             req_b;
    logic [7:0]       psswrd_a;
    logic [7:0]       psswrd_b;
    logic             try_a;
    logic             try_b;
    logic             pass_sensor;
    logic             exit_pulse;
    logic             grant_a;
    logic             grant_b;
    logic             open_gate;
    logic             close_gate;
    logic             alarm_pin;
    logic             alarm_block;
    logic             full;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output req_a, req_b, psswrd_a, psswrd_b, try_a, try_b, pass_sensor, exit_pulse,
        input  grant_a, grant_b, open_gate, close_gate, alarm_pin, alarm_block, full, occupancy
    );

    modport slave (
        input  req_a, req_b, psswrd_a, psswrd_b, try_a, try_b, pass_sensor, exit_pulse,
        output grant_a, grant_b, open_gate, close_gate, alarm_pin, alarm_block, full, occupancy
    );
endinterface

// File: rtl/parking_entry_arbiter.sv
// Round-robin two-lane entry arbiter sharing one PIN check, barrier gate and occupancy count.
// Define PARKING_TIMEOUT_EN to release an idle CHECK grant after TIMEOUT cycles.
module parking_entry_arbiter #(
    parameter logic [7:0] PASSWORD = 8'h57,
    parameter int         CAPACITY = 8,
    parameter int         CNT_W    = 4,
    parameter int         TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    parking_entry_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, OPEN, LOCK, BLOCK} state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    if (CAPACITY < 1 || CAPACITY > (2**CNT_W) - 1 || TIMEOUT < 1) begin : g_param_check
        $error("parking_entry_arbiter: CAPACITY or TIMEOUT out of range");
    end

    state_t           state, state_nxt;
    logic             lane, lane_nxt;       // granted lane, 0 = A
    logic             prio, prio_nxt;       // preferred lane on contention, 0 = A
    logic [1:0]       attempts, attempts_nxt;
    logic             car_in, car_in_nxt;   // a car has entered the passage while OPEN
    logic [CNT_W-1:0] occ, occ_nxt;
    logic             try_a_q, try_b_q, pass_q;
    logic             try_a_edge, try_b_edge, try_g_edge, req_g, pin_ok;
    logic             pass_rise, pass_fall, inc, dec, can_grant, held;
    logic             to_expire;

    function automatic logic pick_lane(input logic p, input logic ra, input logic rb);
        return (ra && rb) ? p : rb;
    endfunction

    assign try_a_edge = bus.try_a & ~try_a_q;
    assign try_b_edge = bus.try_b & ~try_b_q;
    assign try_g_edge = lane ? try_b_edge : try_a_edge;
    assign req_g      = lane ? bus.req_b : bus.req_a;
    assign pin_ok     = ((lane ? bus.psswrd_b : bus.psswrd_a) == PASSWORD);
    assign pass_rise  = bus.pass_sensor & ~pass_q;
    assign pass_fall  = ~bus.pass_sensor & pass_q;

    assign inc = (state == OPEN) && pass_rise && (occ != CAP);
    assign dec = bus.exit_pulse && (occ != '0);

    always_comb begin
        occ_nxt = occ;
        if (inc && !dec)
            occ_nxt = occ + 1'b1;
        else if (dec && !inc)
            occ_nxt = occ - 1'b1;
    end

    // A grant needs a requester and room left after this cycle's count update.
    assign can_grant = (bus.req_a | bus.req_b) && (occ_nxt != CAP);

`ifdef PARKING_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;

    assign to_cnt_nxt = (state == CHECK && !try_g_edge) ? to_cnt + 1'b1 : '0;
    assign to_expire  = (state == CHECK) && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt_nxt;
    end
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        lane_nxt     = lane;
        prio_nxt     = prio;
        attempts_nxt = attempts;
        car_in_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pass_sensor) begin
                    state_nxt = BLOCK;
                end else if (can_grant) begin
                    state_nxt = CHECK;
                    lane_nxt  = pick_lane(prio, bus.req_a, bus.req_b);
                end
            end
            CHECK: begin
                if (bus.pass_sensor) begin
                    state_nxt    = BLOCK;
                    attempts_nxt = '0;
                    prio_nxt     = ~lane;
                end else if (!req_g || (to_expire && !try_g_edge)) begin
                    state_nxt    = IDLE;
                    attempts_nxt = '0;
                    prio_nxt     = ~lane;
                end else if (try_g_edge) begin
                    if (pin_ok) begin
                        state_nxt    = OPEN;
                        attempts_nxt = '0;
                    end else if (attempts == 2'd2) begin
                        state_nxt    = LOCK;
                        attempts_nxt = 2'd3;
                    end else begin
                        attempts_nxt = attempts + 2'd1;
                    end
                end
            end
            OPEN: begin
                car_in_nxt = car_in | pass_rise;
                if (car_in && pass_fall) begin
                    car_in_nxt = 1'b0;
                    prio_nxt   = ~lane;
                    // Hand the gate straight to a waiting lane as it closes.
                    if (can_grant) begin
                        state_nxt = CHECK;
                        lane_nxt  = pick_lane(~lane, bus.req_a, bus.req_b);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            LOCK: begin
                if (try_g_edge && pin_ok) begin
                    state_nxt    = OPEN;
                    attempts_nxt = '0;
                end
            end
            BLOCK: begin
                if (!bus.pass_sensor) begin
                    if (try_a_edge) begin
                        if (bus.psswrd_a == PASSWORD)
                            state_nxt = IDLE;
                    end else if (try_b_edge && bus.psswrd_b == PASSWORD) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        held = (state_nxt == CHECK) || (state_nxt == OPEN) || (state_nxt == LOCK);
    end

    assign bus.occupancy = occ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            lane            <= 1'b0;
            prio            <= 1'b0;
            attempts        <= '0;
            car_in          <= 1'b0;
            occ             <= '0;
            try_a_q         <= 1'b0;
            try_b_q         <= 1'b0;
            pass_q          <= 1'b0;
            bus.grant_a     <= 1'b0;
            bus.grant_b     <= 1'b0;
            bus.open_gate   <= 1'b0;
            bus.close_gate  <= 1'b1;
            bus.alarm_pin   <= 1'b0;
            bus.alarm_block <= 1'b0;
            bus.full        <= 1'b0;
        end else begin
            state           <= state_nxt;
            lane            <= lane_nxt;
            prio            <= prio_nxt;
            attempts        <= attempts_nxt;
            car_in          <= car_in_nxt;
            occ             <= occ_nxt;
            try_a_q         <= bus.try_a;
            try_b_q         <= bus.try_b;
            pass_q          <= bus.pass_sensor;
            bus.grant_a     <= held && !lane_nxt;
            bus.grant_b     <= held && lane_nxt;
            bus.open_gate   <= (state_nxt == OPEN);
            bus.close_gate  <= (state_nxt != OPEN);
            bus.alarm_pin   <= (state_nxt == LOCK);
            bus.alarm_block <= (state_nxt == BLOCK);
            bus.full        <= (occ_nxt == CAP);
        end
    end
endmodule

// File: tb/tb_parking_entry_arbiter.sv
// Table-driven scoreboard bench for parking_entry_arbiter (CAPACITY = 2).
module tb_parking_entry_arbiter;
    localparam logic [7:0] OK  = 8'h57;
    localparam logic [7:0] BAD = 8'h5F;
    localparam logic [7:0] NO  = 8'h00;

    // ctl = {rst, req_a, req_b, try_a, try_b, pass_sensor, exit_pulse}
    // st  = {grant_a, grant_b, open_gate, alarm_pin, alarm_block, full}
    typedef struct packed {
        logic [6:0] ctl;
        logic [7:0] pa;
        logic [7:0] pb;
        logic [5:0] st;
        logic [3:0] occ;
    } row_t;

    typedef struct {
        string       name;
        int          idx;
        logic [10:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    parking_entry_arbiter_if #(.CNT_W(4)) bus ();

    parking_entry_arbiter #(
        .PASSWORD (8'h57),
        .CAPACITY (2),
        .CNT_W    (4),
        .TIMEOUT  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {bus.grant_a, bus.grant_b, bus.open_gate, bus.close_gate,
                bus.alarm_pin, bus.alarm_block, bus.full, bus.occupancy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one row of inputs and queue the outputs it must produce after the next edge.
    task automatic apply(input string name, input int idx, input row_t r);
        exp_t e;
        rst             = r.ctl[6];
        bus.req_a       = r.ctl[5];
        bus.req_b       = r.ctl[4];
        bus.try_a       = r.ctl[3];
        bus.try_b       = r.ctl[2];
        bus.pass_sensor = r.ctl[1];
        bus.exit_pulse  = r.ctl[0];
        bus.psswrd_a    = r.pa;
        bus.psswrd_b    = r.pb;
        e.name = name;
        e.idx  = idx;
        e.v    = {r.st[5], r.st[4], r.st[3], ~r.st[3], r.st[2], r.st[1], r.st[0], r.occ};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows [2] = '{
            '{7'b0000000, NO, NO, 6'b000000, 4'd0},
            '{7'b1000000, NO, NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("reset", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_basic();
        row_t rows [5] = '{
            '{7'b1100000, OK, NO, 6'b100000, 4'd0},
            '{7'b1101000, OK, NO, 6'b101000, 4'd0},
            '{7'b1101010, OK, NO, 6'b101000, 4'd1},
            '{7'b1000000, NO, NO, 6'b000000, 4'd1},
            '{7'b1000001, NO, NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("basic", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_contention();
        row_t rows [10] = '{
            '{7'b0000000, NO, NO, 6'b000000, 4'd0},
            '{7'b1110000, NO, NO, 6'b100000, 4'd0},
            '{7'b1111000, OK, NO, 6'b101000, 4'd0},
            '{7'b1110010, NO, NO, 6'b101000, 4'd1},
            '{7'b1010000, NO, NO, 6'b010000, 4'd1},
            '{7'b1010100, NO, OK, 6'b011000, 4'd1},
            '{7'b1010010, NO, NO, 6'b011001, 4'd2},
            '{7'b1000000, NO, NO, 6'b000001, 4'd2},
            '{7'b1000001, NO, NO, 6'b000000, 4'd1},
            '{7'b1000001, NO, NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("contention", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_capacity();
        row_t rows [16] = '{
            '{7'b1100000, NO, NO, 6'b100000, 4'd0},
            '{7'b1101000, OK, NO, 6'b101000, 4'd0},
            '{7'b1000010, NO, NO, 6'b101000, 4'd1},
            '{7'b1000000, NO, NO, 6'b000000, 4'd1},
            '{7'b1010000, NO, NO, 6'b010000, 4'd1},
            '{7'b1010100, NO, OK, 6'b011000, 4'd1},
            '{7'b1000011, NO, NO, 6'b011000, 4'd1},
            '{7'b1000000, NO, NO, 6'b000000, 4'd1},
            '{7'b1100000, NO, NO, 6'b100000, 4'd1},
            '{7'b1101000, OK, NO, 6'b101000, 4'd1},
            '{7'b1000010, NO, NO, 6'b101001, 4'd2},
            '{7'b1000000, NO, NO, 6'b000001, 4'd2},
            '{7'b1010000, NO, NO, 6'b000001, 4'd2},
            '{7'b1000001, NO, NO, 6'b000000, 4'd1},
            '{7'b1000001, NO, NO, 6'b000000, 4'd0},
            '{7'b1000001, NO, NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("capacity", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_two_wrong();
        row_t rows [9] = '{
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, OK,  NO, 6'b101000, 4'd0},
            '{7'b1100010, NO,  NO, 6'b101000, 4'd1},
            '{7'b1000000, NO,  NO, 6'b000000, 4'd1},
            '{7'b1000001, NO,  NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("two_wrong", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_lock();
        row_t rows [21] = '{
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100100, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100100, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100100, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100100, 4'd0},
            '{7'b0100000, NO,  NO, 6'b000000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100000, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1101000, BAD, NO, 6'b100100, 4'd0},
            '{7'b1100000, NO,  NO, 6'b100100, 4'd0},
            '{7'b1101000, OK,  NO, 6'b101000, 4'd0},
            '{7'b1000010, NO,  NO, 6'b101000, 4'd1},
            '{7'b1000000, NO,  NO, 6'b000000, 4'd1},
            '{7'b1000001, NO,  NO, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("lock", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

    task automatic test_tailgate();
        row_t rows [10] = '{
            '{7'b1100000, NO,  NO, 6'b100000, 4'd0},
            '{7'b1100010, NO,  NO, 6'b000010, 4'd0},
            '{7'b1101010, OK,  NO, 6'b000010, 4'd0},
            '{7'b1100000, NO,  NO, 6'b000010, 4'd0},
            '{7'b1101000, OK,  NO, 6'b000000, 4'd0},
            '{7'b1000010, NO,  NO, 6'b000010, 4'd0},
            '{7'b1000000, NO,  NO, 6'b000010, 4'd0},
            '{7'b1001100, BAD, OK, 6'b000010, 4'd0},
            '{7'b1000000, NO,  NO, 6'b000010, 4'd0},
            '{7'b1000100, NO,  OK, 6'b000000, 4'd0}
        };
        exp_t e;
        foreach (rows[i]) begin
            apply("tailgate", i, rows[i]);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
    endtask

`ifdef PARKING_TIMEOUT_EN
    task automatic test_timeout();
        row_t held_row = '{7'b1100000, NO, NO, 6'b100000, 4'd0};
        row_t gone_row = '{7'b1100000, NO, NO, 6'b000000, 4'd0};
        exp_t e;
        for (int i = 0; i < 17; i++) begin
            apply("timeout", i, (i < 16) ? held_row : gone_row);
            step();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.name, e.idx, observed(), e.v);
            end
        end
        apply("timeout_end", 0, '{7'b1000000, NO, NO, 6'b000000, 4'd0});
        step();
        void'(sb.pop_front());
    endtask
`endif

    initial begin
        rst             = 1'b0;
        bus.req_a       = 1'b0;
        bus.req_b       = 1'b0;
        bus.try_a       = 1'b0;
        bus.try_b       = 1'b0;
        bus.pass_sensor = 1'b0;
        bus.exit_pulse  = 1'b0;
        bus.psswrd_a    = 8'h00;
        bus.psswrd_b    = 8'h00;
        test_reset();
        test_basic();
        test_contention();
        test_capacity();
        test_two_wrong();
        test_lock();
        test_tailgate();
`ifdef PARKING_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
